// File: rtl/xbar_slave_arbiter.sv
// Slave-side arbitration stage of the 4-master crossbar: address filter, arbiter and req/ack relay.
// Define XBAR_RR_ARB_EN for round-robin arbitration; otherwise fixed priority (master 0 highest).
module xbar_slave_arbiter #(
    parameter logic [1:0]  SLAVE_ID = 2'b11,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic [3:0]   iReq,
    input  logic [127:0] iAddr,
    input  logic [127:0] iWdata,
    input  logic [3:0]   iWr,
    output logic [3:0]   oAck,
    output logic         oErr,
    output logic [31:0]  oRdata,
    output logic [3:0]   oGrant,
    output logic         oS_req,
    output logic [31:0]  oS_addr,
    output logic [31:0]  oS_wdata,
    output logic         oS_wr,
    input  logic         iS_ack,
    input  logic [31:0]  iS_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_RESP
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [3:0] w_valid;
    logic       w_any;
    logic       w_found;
    logic [1:0] w_win;
`ifdef XBAR_RR_ARB_EN
    logic [1:0] r_ptr;
    logic [1:0] r_gidx;
    logic [1:0] w_idx;
`endif

    always_comb begin
        w_valid = '0;
        for (int unsigned m = 0; m < 4; m++) begin
            w_valid[m] = iReq[m] && (iAddr[32*m+30 +: 2] == SLAVE_ID);
        end
    end

    assign w_any = |w_valid;

    // First valid master in search order wins; search starts at the pointer in round-robin mode.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
`ifdef XBAR_RR_ARB_EN
        w_idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && w_valid[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
`else
        for (int unsigned i = 0; i < 4; i++) begin
            if (!w_found && w_valid[i]) begin
                w_win   = 2'(i);
                w_found = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            oAck     <= '0;
            oErr     <= 1'b0;
            oRdata   <= '0;
            oGrant   <= '0;
            oS_req   <= 1'b0;
            oS_addr  <= '0;
            oS_wdata <= '0;
            oS_wr    <= 1'b0;
`ifdef XBAR_RR_ARB_EN
            r_ptr    <= '0;
            r_gidx   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        oGrant   <= 4'b0001 << w_win;
                        oS_addr  <= iAddr[32*w_win +: 32];
                        oS_wdata <= iWdata[32*w_win +: 32];
                        oS_wr    <= iWr[w_win];
                        oS_req   <= 1'b1;
                        r_cnt    <= '0;
`ifdef XBAR_RR_ARB_EN
                        r_gidx   <= w_win;
`endif
                        r_state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // A slave ack in the final timeout cycle still completes normally.
                    if (iS_ack) begin
                        if (!oS_wr) begin
                            oRdata <= iS_rdata;
                        end
                        oErr    <= 1'b0;
                        oS_req  <= 1'b0;
                        oAck    <= oGrant;
                        r_state <= ST_RESP;
                    end else if (r_cnt == LP_LAST) begin
                        oErr    <= 1'b1;
                        oS_req  <= 1'b0;
                        oAck    <= oGrant;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    oAck    <= '0;
                    oGrant  <= '0;
`ifdef XBAR_RR_ARB_EN
                    r_ptr   <= r_gidx + 2'd1;
`endif
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
// Scoreboard bench for xbar_slave_arbiter (SLAVE_ID=2'b11, TIMEOUT=4): stimulus queues expectations,
// a monitor checks each slave request and each master acknowledge as the DUT presents it.
module tb_xbar_slave_arbiter;

    typedef struct {
        logic [3:0]  grant;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        int          len;
    } req_t;

    typedef struct {
        logic [3:0]  ack;
        logic        err;
        logic [31:0] rdata;
        int          gap;
    } ack_t;

    logic         iClk;
    logic         iRst_n;
    logic [3:0]   iReq;
    logic [127:0] iAddr;
    logic [127:0] iWdata;
    logic [3:0]   iWr;
    logic [3:0]   oAck;
    logic         oErr;
    logic [31:0]  oRdata;
    logic [3:0]   oGrant;
    logic         oS_req;
    logic [31:0]  oS_addr;
    logic [31:0]  oS_wdata;
    logic         oS_wr;
    logic         iS_ack;
    logic [31:0]  iS_rdata;

    int   tests;
    int   fails;
    req_t req_q[$];
    ack_t ack_q[$];

    int          slave_delay;
    logic        slave_spurious;
    logic [31:0] slave_rdata;

    xbar_slave_arbiter #(
        .SLAVE_ID (2'b11),
        .TIMEOUT  (4)
    ) dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iReq     (iReq),
        .iAddr    (iAddr),
        .iWdata   (iWdata),
        .iWr      (iWr),
        .oAck     (oAck),
        .oErr     (oErr),
        .oRdata   (oRdata),
        .oGrant   (oGrant),
        .oS_req   (oS_req),
        .oS_addr  (oS_addr),
        .oS_wdata (oS_wdata),
        .oS_wr    (oS_wr),
        .iS_ack   (iS_ack),
        .iS_rdata (iS_rdata)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_txn(input logic [3:0] g, input logic [31:0] a, input logic [31:0] w,
                           input logic wr, input int len, input logic err,
                           input logic [31:0] rd, input int gap);
        req_t r;
        ack_t k;
        r.grant = g; r.addr = a; r.wdata = w; r.wr = wr; r.len = len;
        k.ack = g; k.err = err; k.rdata = rd; k.gap = gap;
        req_q.push_back(r);
        ack_q.push_back(k);
    endtask

    task automatic set_master(input int m, input logic [31:0] a, input logic [31:0] w, input logic wr);
        iAddr[32*m +: 32]  = a;
        iWdata[32*m +: 32] = w;
        iWr[m]             = wr;
    endtask

    // Masters drop their request on seeing oAck, except those in hold, which keep requesting until n acks.
    task automatic run_until(input int n, input logic [3:0] hold, input int budget);
        int seen;
        int c;
        seen = 0;
        c    = 0;
        while (seen < n && c < budget) begin
            @(negedge iClk);
            c++;
            if (oAck != 4'b0000) begin
                seen++;
                iReq = iReq & ~(oAck & ~hold);
                if (seen == n) iReq = iReq & ~hold;
            end
        end
        chk("ack_count", 32'(seen), 32'(n));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_oAck"},     32'(oAck),     32'd0);
        chk({tag, "_oErr"},     32'(oErr),     32'd0);
        chk({tag, "_oRdata"},   oRdata,        32'd0);
        chk({tag, "_oGrant"},   32'(oGrant),   32'd0);
        chk({tag, "_oS_req"},   32'(oS_req),   32'd0);
        chk({tag, "_oS_addr"},  oS_addr,       32'd0);
        chk({tag, "_oS_wdata"}, oS_wdata,      32'd0);
        chk({tag, "_oS_wr"},    32'(oS_wr),    32'd0);
    endtask

    // Slave model: acks after slave_delay cycles of oS_req (never if <= 0); may pulse ack while idle.
    initial begin
        int cnt;
        cnt      = 0;
        iS_ack   = 1'b0;
        iS_rdata = '0;
        forever begin
            @(negedge iClk);
            if (oS_req) begin
                cnt++;
                iS_ack = (slave_delay > 0) && (cnt == slave_delay);
            end else begin
                cnt    = 0;
                iS_ack = slave_spurious;
            end
            iS_rdata = slave_rdata;
        end
    end

    // Monitor: checks slave-side fields when oS_req rises, its length when it falls, and every oAck.
    initial begin
        req_t cur;
        ack_t a;
        logic prev_req;
        logic prev_ack;
        logic active;
        int   len;
        int   cyc;
        int   last_ack;
        prev_req = 1'b0; prev_ack = 1'b0; active = 1'b0;
        len = 0; cyc = 0; last_ack = 0;
        cur.len = 0;
        forever begin
            @(posedge iClk);
            #1;
            cyc++;
            if (!iRst_n) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
                active   = 1'b0;
            end else begin
                if (oS_req && !prev_req) begin
                    if (req_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_req: got grant %b, expected no request", oGrant);
                        active = 1'b0;
                    end else begin
                        cur = req_q.pop_front();
                        chk("req_grant", 32'(oGrant), 32'(cur.grant));
                        chk("req_addr",  oS_addr,     cur.addr);
                        chk("req_wdata", oS_wdata,    cur.wdata);
                        chk("req_wr",    32'(oS_wr),  32'(cur.wr));
                        active = 1'b1;
                        len    = 0;
                    end
                end
                if (oS_req) len++;
                if (!oS_req && prev_req && active) begin
                    if (cur.len > 0) chk("req_len", 32'(len), 32'(cur.len));
                    active = 1'b0;
                end
                if (oAck != 4'b0000) begin
                    chk("ack_onehot", 32'($countones(oAck)), 32'd1);
                    chk("ack_after_req", 32'(prev_req), 32'd1);
                    chk("ack_not_back_to_back", 32'(prev_ack), 32'd0);
                    if (ack_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_ack: got oAck %b, expected none", oAck);
                    end else begin
                        a = ack_q.pop_front();
                        chk("ack_bits",  32'(oAck),   32'(a.ack));
                        chk("ack_grant", 32'(oGrant), 32'(a.ack));
                        chk("ack_err",   32'(oErr),   32'(a.err));
                        chk("ack_rdata", oRdata,      a.rdata);
                        if (a.gap > 0) chk("ack_gap", 32'(cyc - last_ack), 32'(a.gap));
                    end
                    last_ack = cyc;
                end
                prev_req = oS_req;
                prev_ack = (oAck != 4'b0000);
            end
        end
    end

    initial begin
        int c;
        logic [31:0] cdata [4];
        tests = 0;
        fails = 0;
        iRst_n = 1'b0; iReq = '0; iAddr = '0; iWdata = '0; iWr = '0;
        slave_delay = 1; slave_spurious = 1'b0; slave_rdata = '0;
        cdata[0] = 32'h11; cdata[1] = 32'h22; cdata[2] = 32'h33; cdata[3] = 32'h44;

        repeat (3) @(negedge iClk);
        chk_all_zero("reset");
        iRst_n = 1'b1;

        // Contention: all four write together, slave acks in first XFER cycle.
        for (int m = 0; m < 4; m++) begin
            set_master(m, 32'hC000_0000, cdata[m], 1'b1);
            exp_txn(4'(1 << m), 32'hC000_0000, cdata[m], 1'b1, 1, 1'b0, 32'h0, (m == 0) ? 0 : 3);
        end
        iReq = 4'hF;
        run_until(4, 4'b0000, 60);

        // Address filter with spurious idle acks; only master 0 targets this slave.
        slave_spurious = 1'b1;
        set_master(0, 32'hC000_0010, 32'hA0, 1'b1);
        set_master(1, 32'h8000_0000, 32'hA1, 1'b1);
        set_master(2, 32'h4000_0000, 32'hA2, 1'b1);
        set_master(3, 32'h0000_0000, 32'hA3, 1'b1);
        exp_txn(4'b0001, 32'hC000_0010, 32'hA0, 1'b1, 1, 1'b0, 32'h0, 0);
        iReq = 4'hF;
        run_until(1, 4'b0000, 40);
        repeat (8) @(negedge iClk);
        chk("filter_idle_grant", 32'(oGrant), 32'd0);
        chk("filter_idle_req",   32'(oS_req), 32'd0);
        iReq = '0;

        // Read from master 1.
        set_master(1, 32'hC000_0004, 32'h77, 1'b0);
        slave_rdata = 32'hDEAD_BEEF;
        slave_delay = 2;
        exp_txn(4'b0010, 32'hC000_0004, 32'h77, 1'b0, 2, 1'b0, 32'hDEAD_BEEF, 0);
        iReq = 4'b0010;
        run_until(1, 4'b0000, 40);
        slave_spurious = 1'b0;

        // Timeout, then ack on the last timeout cycle, then a normal read.
        slave_delay = 0;
        set_master(2, 32'hC000_0008, 32'h55, 1'b1);
        exp_txn(4'b0100, 32'hC000_0008, 32'h55, 1'b1, 4, 1'b1, 32'hDEAD_BEEF, 0);
        iReq = 4'b0100;
        run_until(1, 4'b0000, 40);
        slave_delay = 4;
        set_master(3, 32'hC000_000C, 32'h66, 1'b1);
        exp_txn(4'b1000, 32'hC000_000C, 32'h66, 1'b1, 4, 1'b0, 32'hDEAD_BEEF, 0);
        iReq = 4'b1000;
        run_until(1, 4'b0000, 40);
        slave_delay = 1;
        slave_rdata = 32'h0BAD_F00D;
        set_master(0, 32'hC000_0000, 32'h0, 1'b0);
        exp_txn(4'b0001, 32'hC000_0000, 32'h0, 1'b0, 1, 1'b0, 32'h0BAD_F00D, 0);
        iReq = 4'b0001;
        run_until(1, 4'b0000, 40);

        // Reset during XFER: aborted transfer gets no ack; requests then re-arbitrate.
        slave_delay = 0;
        set_master(1, 32'hC000_0100, 32'h101, 1'b1);
        set_master(3, 32'hC000_0300, 32'h303, 1'b1);
        begin
            req_t r;
            r.grant = 4'b0010; r.addr = 32'hC000_0100; r.wdata = 32'h101; r.wr = 1'b1; r.len = 0;
            req_q.push_back(r);
        end
        iReq = 4'b1010;
        c = 0;
        while (!oS_req && c < 20) begin
            @(negedge iClk);
            c++;
        end
        chk("rst_wait_req", 32'(oS_req), 32'd1);
        @(negedge iClk);
        iRst_n = 1'b0;
        @(negedge iClk);
        chk_all_zero("midrst");
        exp_txn(4'b0010, 32'hC000_0100, 32'h101, 1'b1, 1, 1'b0, 32'h0, 0);
        exp_txn(4'b1000, 32'hC000_0300, 32'h303, 1'b1, 1, 1'b0, 32'h0, 3);
        slave_delay = 1;
        iRst_n = 1'b1;
        run_until(2, 4'b0000, 40);

        // Masters 0 and 2 request continuously.
        set_master(0, 32'hC000_0000, 32'hA5A5, 1'b1);
        set_master(2, 32'hC000_0020, 32'h5A5A, 1'b1);
        for (int k = 0; k < 4; k++) begin
`ifdef XBAR_RR_ARB_EN
            if (k % 2 == 0)
                exp_txn(4'b0001, 32'hC000_0000, 32'hA5A5, 1'b1, 1, 1'b0, 32'h0, (k == 0) ? 0 : 3);
            else
                exp_txn(4'b0100, 32'hC000_0020, 32'h5A5A, 1'b1, 1, 1'b0, 32'h0, 3);
`else
            exp_txn(4'b0001, 32'hC000_0000, 32'hA5A5, 1'b1, 1, 1'b0, 32'h0, (k == 0) ? 0 : 3);
`endif
        end
        iReq = 4'b0101;
        run_until(4, 4'b0101, 60);

        repeat (6) @(negedge iClk);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
